sram_req_arbiter: RTL and testbench

//  Shares a single downstream sram-like port (req/addr_ok/data_ok) between the

---
 rtl/sram_req_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_req_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-master arbiter for a shared sram-like port: grants one address handshake
// at a time, remembers issuer order, and steers each response back to its issuer.
module sram_req_arbiter #(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [2:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [2:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [2:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW:0]   DEPTH      = (PW+1)'(OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] cnt);
    return (cnt == STARVE_MAX) ? cnt : cnt + SW'(1);
  endfunction

  logic                   lock_vld;
  logic                   lock_id;
  logic [SW-1:0]          starve_cnt;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW:0]            count;
  logic [OUTSTANDING-1:0] id_fifo;

  logic gnt_id;
  logic req_sel;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic head_id;

  // A pending handshake keeps its master; otherwise data wins unless inst has starved.
  always_comb begin
    gnt_id = 1'b0;
    if (lock_vld)
      gnt_id = lock_id;
    else if (data_req && !(inst_req && starve_cnt == STARVE_MAX))
      gnt_id = 1'b1;
  end

  assign req_sel    = gnt_id ? data_req : inst_req;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH);
  assign pop        = resetn & mem_data_ok & ~fifo_empty;
  // A response retiring this cycle frees the slot the new request will take.
  assign mem_req    = resetn & req_sel & ~(fifo_full & ~pop);
  assign push       = mem_req & mem_addr_ok;
  assign head_id    = id_fifo[rd_ptr];

  assign mem_wr    = gnt_id ? data_wr    : inst_wr;
  assign mem_size  = gnt_id ? data_size  : inst_size;
  assign mem_wstrb = gnt_id ? data_wstrb : inst_wstrb;
  assign mem_addr  = gnt_id ? data_addr  : inst_addr;
  assign mem_wdata = gnt_id ? data_wdata : inst_wdata;

  assign inst_addr_ok = push & ~gnt_id;
  assign data_addr_ok = push &  gnt_id;
  assign inst_data_ok = pop  & ~head_id;
  assign data_data_ok = pop  &  head_id;
  assign inst_rdata   = resetn ? mem_rdata : '0;
  assign data_rdata   = resetn ? mem_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld   <= 1'b0;
      lock_id    <= 1'b0;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (push)
        lock_vld <= 1'b0;
      else if (mem_req) begin
        lock_vld <= 1'b1;
        lock_id  <= gnt_id;
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase

      if (!inst_req || (push && !gnt_id))
        starve_cnt <= '0;
      else if (push && gnt_id)
        starve_cnt <= starve_inc(starve_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= gnt_id;
  end

  a_no_orphan_response: assert property (@(posedge clk) disable iff (!resetn)
    !(mem_data_ok && fifo_empty))
    else $warning("sram_req_arbiter: mem_data_ok with no outstanding request, ignored");

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized and directed stimulus for sram_req_arbiter; a per-cycle reference
// model predicts grants and a scoreboard matches every response to its request.
module tb_sram_req_arbiter;
  localparam int OUT = 4;
  localparam int LIM = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        inst_req = 0, inst_wr = 0;
  logic [2:0]  inst_size = 0;
  logic [3:0]  inst_wstrb = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0;
  logic [2:0]  data_size = 0;
  logic [3:0]  data_wstrb = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [2:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;

  sram_req_arbiter #(.OUTSTANDING(OUT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  int checks = 0, errors = 0;
  int inst_pct = 0, data_pct = 0, aok_pct = 0, dok_pct = 0;
  bit dok_force = 0;
  bit inst_acc = 0, data_acc = 0;
  logic [31:0] inst_exp_q[$], data_exp_q[$], br_q[$];
  int m_ids[$];
  int m_lock = -1, m_starve = 0;
  int grant_log[$], resp_log[$];

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packs the first n log entries, entry i at bit i.
  task automatic chk_log(input string name, input int q[$], input int n, input logic [31:0] exp);
    logic [31:0] v = '0;
    chk({name, "_len"}, 32'(q.size() >= n), 32'd1);
    for (int i = 0; i < n && i < q.size(); i++) v[i] = (q[i] != 0);
    chk(name, v, exp);
  endtask

  // Reference model and scoreboard, evaluated mid-cycle once inputs are stable.
  always @(negedge clk) begin : monitor
    int cnt, pick;
    bit pop_ok, blocked, exp_req, hs;
    if (!resetn) begin
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 0);
      chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
      chk("rst_inst_rdata", inst_rdata, 0);
      chk("rst_data_rdata", data_rdata, 0);
      m_ids.delete(); br_q.delete();
      m_lock = -1; m_starve = 0; inst_acc = 0; data_acc = 0;
    end else begin
      cnt = m_ids.size();
      pop_ok = mem_data_ok && cnt > 0;
      blocked = (cnt == OUT) && !pop_ok;
      if (m_lock >= 0) pick = m_lock;
      else if (data_req && !(inst_req && m_starve == LIM)) pick = 1;
      else if (inst_req) pick = 0;
      else pick = -1;
      exp_req = ((pick == 1 && data_req) || (pick == 0 && inst_req)) && !blocked;
      hs = exp_req && mem_addr_ok;

      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req && mem_req) begin
        chk("mem_addr", mem_addr, (pick == 1) ? data_addr : inst_addr);
        chk("mem_wdata", mem_wdata, (pick == 1) ? data_wdata : inst_wdata);
        chk("mem_ctrl", 32'({mem_wr, mem_size, mem_wstrb}),
            (pick == 1) ? 32'({data_wr, data_size, data_wstrb}) : 32'({inst_wr, inst_size, inst_wstrb}));
      end
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(hs && pick == 0));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(hs && pick == 1));
      chk("inst_data_ok", 32'(inst_data_ok), 32'(pop_ok && m_ids[0] == 0));
      chk("data_data_ok", 32'(data_data_ok), 32'(pop_ok && m_ids[0] == 1));

      if (inst_data_ok) begin
        if (inst_exp_q.size() == 0) chk("inst_resp_unexpected", 32'd1, 32'd0);
        else chk("inst_rdata", inst_rdata, resp_of(inst_exp_q.pop_front()));
        resp_log.push_back(0);
      end
      if (data_data_ok) begin
        if (data_exp_q.size() == 0) chk("data_resp_unexpected", 32'd1, 32'd0);
        else chk("data_rdata", data_rdata, resp_of(data_exp_q.pop_front()));
        resp_log.push_back(1);
      end
      if (inst_addr_ok) begin inst_acc = 1; grant_log.push_back(0); end
      if (data_addr_ok) begin data_acc = 1; grant_log.push_back(1); end

      if (mem_data_ok && br_q.size() > 0) void'(br_q.pop_front());
      if (mem_req && mem_addr_ok) br_q.push_back(mem_addr);

      if (pop_ok) void'(m_ids.pop_front());
      if (hs) m_ids.push_back(pick);
      if (hs) m_lock = -1; else if (exp_req) m_lock = pick;
      if (!inst_req || (hs && pick == 0)) m_starve = 0;
      else if (hs && pick == 1 && m_starve < LIM) m_starve++;
    end
  end

  task automatic issue_inst(input logic [31:0] a);
    inst_req = 1; inst_wr = 0; inst_size = 3'd2; inst_wstrb = 4'hf;
    inst_addr = a; inst_wdata = $urandom; inst_exp_q.push_back(a);
  endtask

  task automatic issue_data(input logic [31:0] a);
    data_req = 1; data_wr = 1'($urandom); data_size = 3'($urandom_range(2));
    data_wstrb = 4'($urandom); data_addr = a; data_wdata = $urandom; data_exp_q.push_back(a);
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (inst_req && inst_acc) inst_req = 0;
    if (data_req && data_acc) data_req = 0;
    inst_acc = 0; data_acc = 0;
    if (!inst_req && $urandom_range(99) < inst_pct) issue_inst($urandom & 32'hffff_fffc);
    if (!data_req && $urandom_range(99) < data_pct) issue_data($urandom & 32'hffff_fffc);
    mem_addr_ok = ($urandom_range(99) < aok_pct);
    mem_data_ok = dok_force || (br_q.size() > 0 && $urandom_range(99) < dok_pct);
    mem_rdata = (br_q.size() > 0) ? resp_of(br_q[0]) : $urandom;
  endtask

  task automatic sample();
    @(negedge clk); #2;
  endtask

  task automatic drain(input string name);
    int n = 0;
    inst_pct = 0; data_pct = 0; aok_pct = 100; dok_pct = 100; dok_force = 0;
    while ((inst_req || data_req || br_q.size() > 0) && n < 300) begin step(); n++; end
    step(); step();
    chk({name, "_drained"}, 32'(n < 300), 32'd1);
    chk({name, "_inst_left"}, 32'(inst_exp_q.size()), 32'd0);
    chk({name, "_data_left"}, 32'(data_exp_q.size()), 32'd0);
  endtask

  task automatic clear_logs();
    grant_log.delete(); resp_log.delete();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    sample();
    chk("reset_mem_req", 32'(mem_req), 0);
    @(posedge clk); #1 resetn = 1;

    // Single instruction fetch
    clear_logs(); aok_pct = 0; dok_pct = 0;
    step(); issue_inst(32'h1c00_0000);
    aok_pct = 100; step();
    aok_pct = 0; step(); step();
    dok_pct = 100; step();
    dok_pct = 0; step(); step();
    chk_log("t1_grants", grant_log, 1, 32'h0);
    chk("t1_resp_cnt", 32'(resp_log.size()), 32'd1);

    // Simultaneous requests: data first, then inst
    clear_logs(); aok_pct = 100; step();
    issue_inst(32'h1c00_0040); issue_data(32'h0000_1000);
    drain("t2");
    chk_log("t2_grants", grant_log, 2, 32'h1);
    chk_log("t2_resps", resp_log, 2, 32'h1);

    // Stalled handshake is not preempted by a later data request
    clear_logs(); aok_pct = 0; dok_pct = 0; step();
    issue_inst(32'h1c00_0080); step();
    issue_data(32'h0000_2000); step();
    sample();
    chk("t3_mem_req", 32'(mem_req), 32'd1);
    chk("t3_mem_addr", mem_addr, 32'h1c00_0080);
    aok_pct = 100; step();
    drain("t3");
    chk_log("t3_grants", grant_log, 2, 32'h2);

    // FIFO fills, then a response frees a slot in the same cycle
    clear_logs(); aok_pct = 100; dok_pct = 0; inst_pct = 100; data_pct = 100;
    repeat (8) step();
    sample();
    chk("t4_full_mem_req", 32'(mem_req), 32'd0);
    chk("t4_full_grants", 32'(grant_log.size()), 32'd4);
    dok_pct = 100; step();
    sample();
    chk("t4_pushpop_mem_req", 32'(mem_req), 32'd1);
    chk("t4_pushpop_grants", 32'(grant_log.size()), 32'd5);
    dok_pct = 0; step();
    sample();
    chk("t4_refull_mem_req", 32'(mem_req), 32'd0);
    drain("t4");

    // Starvation guard: D,D,D,I repeating
    clear_logs(); aok_pct = 100; dok_pct = 100; inst_pct = 100; data_pct = 100;
    repeat (8) step();
    sample();
    chk_log("t5_grants", grant_log, 8, 32'h77);
    drain("t5");

    // Reset with two requests outstanding
    clear_logs(); aok_pct = 100; dok_pct = 0; step();
    issue_inst(32'h1c00_0100); issue_data(32'h0000_3000);
    step(); step(); step();
    resetn = 0; mem_data_ok = 1; mem_rdata = 32'hdead_beef; inst_req = 1; data_req = 1;
    #1;
    chk("t6_mem_req", 32'(mem_req), 32'd0);
    chk("t6_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk("t6_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("t6_inst_rdata", inst_rdata, 32'd0);
    chk("t6_data_rdata", data_rdata, 32'd0);
    inst_req = 0; data_req = 0; inst_exp_q.delete(); data_exp_q.delete();
    aok_pct = 0; dok_pct = 0;
    step(); step();
    resetn = 1; dok_force = 1; step();
    sample();
    chk("t6_orphan_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    dok_force = 0; clear_logs(); step();
    issue_inst(32'h1c00_0140);
    drain("t6");
    chk_log("t6_after_resps", resp_log, 1, 32'h0);

    // Randomized traffic
    clear_logs(); inst_pct = 40; data_pct = 50; aok_pct = 60; dok_pct = 50;
    repeat (1500) step();
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
